nf_i_fu: RTL

//  Instruction fetch unit: holds the PC, fetches from instruction memory over a req/ack bus, and presents

---
 rtl/nf_i_fu.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/nf_i_fu.sv
// nf_i_fu: instruction fetch unit.
// Holds the PC and fetches over a req/ack bus. It presents instr_if/pc_if/instr_vld to decode
// and accepts redirects (pc_src/pc_branch) from decode.
// A one-entry skid buffer keeps a completed fetch that arrives while decode is stalled.
// Optional feature macro: NF_I_FU_ALIGN_CHECK_EN.
//  - Defined: a misaligned redirect target puts the unit into a sticky ERR state and drives
//    instr_misalign.
//  - Undefined: the port does not exist and the target's low two bits are forced to zero.
module nf_i_fu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [31:0] instr_rd,
  input  logic        stall_if,
  input  logic        pc_src,
  input  logic [31:0] pc_branch,
  output logic [31:0] instr_if,
  output logic [31:0] pc_if,
`ifdef NF_I_FU_ALIGN_CHECK_EN
  output logic        instr_misalign,
`endif
  output logic        instr_vld
);

`ifdef NF_I_FU_ALIGN_CHECK_EN
  typedef enum logic [2:0] {RST_WAIT, FETCH, HOLD, DROP, ERR} state_t;
`else
  typedef enum logic [1:0] {RST_WAIT, FETCH, HOLD, DROP} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] instr_if_q, instr_if_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic        vld_q, vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        consume;
  logic        redirect;
  logic        target_bad;
  logic [31:0] target;

  // Decode handshake: an output is taken when valid and not stalled; a redirect rides on that.
  assign consume  = vld_q & ~stall_if;
  assign redirect = consume & pc_src;
  assign target   = {pc_branch[31:2], 2'b00};

`ifdef NF_I_FU_ALIGN_CHECK_EN
  assign target_bad     = |pc_branch[1:0];
  assign instr_misalign = (state_q == ERR);
`else
  // Low target bits are dropped; without the check they have no consumer.
  logic [1:0] unused_branch_lo;
  assign unused_branch_lo = pc_branch[1:0];
  assign target_bad       = 1'b0;
`endif

  // Bus drive: DROP keeps presenting the abandoned address until its ack retires it.
  assign instr_req  = (state_q == FETCH) || (state_q == DROP);
  assign instr_addr = (state_q == DROP) ? drop_addr_q : pc_q;
  assign instr_if   = instr_if_q;
  assign pc_if      = pc_if_q;
  assign instr_vld  = vld_q;

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    instr_if_d   = instr_if_q;
    pc_if_d      = pc_if_q;
    vld_d        = vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    case (state_q)
      RST_WAIT: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (redirect) begin
          // Whatever the bus returns this cycle belongs to the wrong path.
          vld_d      = 1'b0;
          instr_if_d = NOP_INSTR;
          pc_d       = target;
          if (target_bad) begin
`ifdef NF_I_FU_ALIGN_CHECK_EN
            state_d = ERR;
`endif
          end else if (!instr_ack) begin
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (instr_ack) begin
          pc_d = pc_q + 32'd4;
          if (!vld_q || consume) begin
            instr_if_d = instr_rd;
            pc_if_d    = pc_q;
            vld_d      = 1'b1;
          end else begin
            // Output is occupied and stalled: park the word in the skid.
            skid_instr_d = instr_rd;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end else if (consume) begin
          vld_d      = 1'b0;
          instr_if_d = NOP_INSTR;
        end
      end

      HOLD: begin
        if (redirect) begin
          vld_d      = 1'b0;
          instr_if_d = NOP_INSTR;
          pc_d       = target;
          state_d    = FETCH;
`ifdef NF_I_FU_ALIGN_CHECK_EN
          if (target_bad) state_d = ERR;
`endif
        end else if (consume) begin
          instr_if_d = skid_instr_q;
          pc_if_d    = skid_pc_q;
          vld_d      = 1'b1;
          state_d    = FETCH;
        end
      end

      DROP: begin
        if (instr_ack) state_d = FETCH;
      end

`ifdef NF_I_FU_ALIGN_CHECK_EN
      ERR: begin
        vld_d      = 1'b0;
        instr_if_d = NOP_INSTR;
      end
`endif

      default: begin
        state_d = RST_WAIT;
      end
    endcase
  end

  // State and datapath registers; reset also abandons any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RST_WAIT;
      pc_q         <= RESET_PC;
      drop_addr_q  <= 32'h0;
      instr_if_q   <= NOP_INSTR;
      pc_if_q      <= 32'h0;
      vld_q        <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      instr_if_q   <= instr_if_d;
      pc_if_q      <= pc_if_d;
      vld_q        <= vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule
